// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: occupancy states and
// default parameter values.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

    localparam int DEF_DATA_W  = 96;
    localparam int DEF_CTRL_W  = 16;
    localparam int DEF_SKID_EN = 1;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment and
// the count sticks at all-ones instead of wrapping.
module pipe_sat_cnt
    import pipe_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// flush, NOP bubbles and stall/bubble performance counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CTRL_W  = DEF_CTRL_W,
    parameter int SKID_EN = DEF_SKID_EN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    pipe_state_t       state_reg, state_next;
    logic [CTRL_W-1:0] head_ctrl_reg, head_ctrl_next;
    logic [DATA_W-1:0] head_data_reg, head_data_next;
    logic [CTRL_W-1:0] skid_ctrl_reg, skid_ctrl_next;
    logic [DATA_W-1:0] skid_data_reg, skid_data_next;
    logic              in_fire;
    logic              out_fire;

    assign out_valid = (state_reg != ST_EMPTY);

    // With the skid buffer, in_ready comes only from registered state so the
    // downstream ready never reaches upstream combinationally.
    generate
        if (SKID_EN != 0) begin : g_skid_ready
            assign in_ready = (state_reg != ST_FULL);
        end else begin : g_reg_ready
            assign in_ready = !out_valid | out_ready;
        end
    endgenerate

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_next     = state_reg;
        head_ctrl_next = head_ctrl_reg;
        head_data_next = head_data_reg;
        skid_ctrl_next = skid_ctrl_reg;
        skid_data_next = skid_data_reg;
        if (flush) begin
            // Data registers are deliberately left alone: only control is killed.
            state_next     = ST_EMPTY;
            head_ctrl_next = '0;
            skid_ctrl_next = '0;
        end else if (SKID_EN != 0) begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_fire) begin
                        head_ctrl_next = in_ctrl;
                        head_data_next = in_data;
                        state_next     = ST_HALF;
                    end
                end
                ST_HALF: begin
                    if (in_fire && out_fire) begin
                        head_ctrl_next = in_ctrl;
                        head_data_next = in_data;
                    end else if (in_fire) begin
                        skid_ctrl_next = in_ctrl;
                        skid_data_next = in_data;
                        state_next     = ST_FULL;
                    end else if (out_fire) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        head_ctrl_next = skid_ctrl_reg;
                        head_data_next = skid_data_reg;
                        state_next     = ST_HALF;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end else begin
            if (in_fire) begin
                head_ctrl_next = in_ctrl;
                head_data_next = in_data;
                state_next     = ST_HALF;
            end else if (out_fire) begin
                state_next = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg     <= ST_EMPTY;
            head_ctrl_reg <= '0;
            head_data_reg <= '0;
            skid_ctrl_reg <= '0;
            skid_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            head_ctrl_reg <= head_ctrl_next;
            head_data_reg <= head_data_next;
            skid_ctrl_reg <= skid_ctrl_next;
            skid_data_reg <= skid_data_next;
        end
    end

    // Bubbles present as NOPs downstream; data simply holds.
    assign out_ctrl = out_valid ? head_ctrl_reg : '0;
    assign out_data = head_data_reg;

    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (cnt_clr),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (cnt_clr),
        .inc   (~out_valid & out_ready),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: one skid-buffered stage (4-bit counters) and one single-register
// stage driven by the same inputs.
module tb_pipe_stage_reg;

    localparam int DATA_W = 96;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;
    logic              flush;
    logic              cnt_clr;

    logic              s_in_ready, s_out_valid;
    logic [CTRL_W-1:0] s_out_ctrl;
    logic [DATA_W-1:0] s_out_data;
    logic [CNT_W-1:0]  s_stall_cnt, s_bubble_cnt;

    logic              r_in_ready, r_out_valid;
    logic [CTRL_W-1:0] r_out_ctrl;
    logic [DATA_W-1:0] r_out_data;
    logic [CNT_W-1:0]  r_stall_cnt, r_bubble_cnt;

    int checks   = 0;
    int failures = 0;

    pipe_stage_reg #(
        .DATA_W (DATA_W), .CTRL_W (CTRL_W), .SKID_EN (1), .CNT_W (CNT_W)
    ) u_skid (
        .CLK        (clk),
        .RST_N      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (s_in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .out_valid  (s_out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (s_out_ctrl),
        .out_data   (s_out_data),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .stall_cnt  (s_stall_cnt),
        .bubble_cnt (s_bubble_cnt)
    );

    pipe_stage_reg #(
        .DATA_W (DATA_W), .CTRL_W (CTRL_W), .SKID_EN (0), .CNT_W (CNT_W)
    ) u_reg (
        .CLK        (clk),
        .RST_N      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (r_in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .out_valid  (r_out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (r_out_ctrl),
        .out_data   (r_out_data),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .stall_cnt  (r_stall_cnt),
        .bubble_cnt (r_bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns 1 ns after the rising edge, so registered outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        cnt_clr   = 1'b0;

        tick();
        check("rst_out_valid", 128'(s_out_valid), 128'd0);
        check("rst_out_ctrl", 128'(s_out_ctrl), 128'd0);
        check("rst_out_data", 128'(s_out_data), 128'd0);
        check("rst_stall", 128'(s_stall_cnt), 128'd0);
        check("rst_bubble", 128'(s_bubble_cnt), 128'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 128'(s_in_ready), 128'd1);

        // Streaming 1..4 with downstream always ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = DATA_W'(i);
            in_ctrl = CTRL_W'(16 + i);
            #1;
            check($sformatf("stream_in_ready_%0d", i), 128'(s_in_ready), 128'd1);
            tick();
            check($sformatf("stream_valid_%0d", i), 128'(s_out_valid), 128'd1);
            check($sformatf("stream_data_%0d", i), 128'(s_out_data), 128'(i));
            check($sformatf("stream_ctrl_%0d", i), 128'(s_out_ctrl), 128'(16 + i));
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", 128'(s_out_valid), 128'd0);
        check("drain_ctrl_nop", 128'(s_out_ctrl), 128'd0);
        check("drain_data_hold", 128'(s_out_data), 128'd4);

        // Skid fill: 0xA then 0xB with 3 stalled cycles
        out_ready = 1'b0;
        cnt_clr   = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_stall", 128'(s_stall_cnt), 128'd0);
        check("clr_bubble", 128'(s_bubble_cnt), 128'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 96'hA;
        in_ctrl   = 16'h00A0;
        tick();
        out_ready = 1'b0;
        in_data   = 96'hB;
        in_ctrl   = 16'h00B0;
        tick();
        check("fill_full_in_ready", 128'(s_in_ready), 128'd0);
        in_valid = 1'b0;
        tick();
        tick();
        check("fill_in_ready", 128'(s_in_ready), 128'd0);
        check("fill_stall", 128'(s_stall_cnt), 128'd3);
        check("fill_bubble", 128'(s_bubble_cnt), 128'd1);
        check("fill_head", 128'(s_out_data), 128'hA);
        out_ready = 1'b1;
        #1;
        check("fill_in_ready_reg_only", 128'(s_in_ready), 128'd0);
        tick();
        check("drain_a_to_b", 128'(s_out_data), 128'hB);
        check("drain_b_ctrl", 128'(s_out_ctrl), 128'h00B0);
        check("drain_in_ready", 128'(s_in_ready), 128'd1);
        tick();
        check("drain_empty", 128'(s_out_valid), 128'd0);
        check("drain_stall_hold", 128'(s_stall_cnt), 128'd3);

        // Flush while FULL with a beat offered in the same cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 96'h55;
        in_ctrl   = 16'h0005;
        tick();
        in_data = 96'h66;
        in_ctrl = 16'h0006;
        tick();
        check("pre_flush_full", 128'(s_in_ready), 128'd0);
        flush   = 1'b1;
        in_data = 96'h77;
        in_ctrl = 16'h0007;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 128'(s_out_valid), 128'd0);
        check("flush_ctrl", 128'(s_out_ctrl), 128'd0);
        check("flush_data_hold", 128'(s_out_data), 128'h55);
        check("flush_in_ready", 128'(s_in_ready), 128'd1);
        out_ready = 1'b1;
        tick();
        check("flush_no_deliver", 128'(s_out_valid), 128'd0);
        check("flush_data_hold2", 128'(s_out_data), 128'h55);

        // Saturation of the 4-bit stall counter
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 96'h99;
        in_ctrl   = 16'h0009;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("sat_stall", 128'(s_stall_cnt), 128'd15);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("sat_clr", 128'(s_stall_cnt), 128'd0);
        tick();
        check("sat_resume", 128'(s_stall_cnt), 128'd1);

        // Asynchronous reset while HALF
        check("half_valid", 128'(s_out_valid), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 128'(s_out_valid), 128'd0);
        check("arst_stall", 128'(s_stall_cnt), 128'd0);
        check("arst_bubble", 128'(s_bubble_cnt), 128'd0);
        check("arst_data", 128'(s_out_data), 128'd0);
        check("arst_reg_valid", 128'(r_out_valid), 128'd0);
        rst_n = 1'b1;
        #1;
        check("arst_release_in_ready", 128'(s_in_ready), 128'd1);
        tick();
        check("arst_stays_empty", 128'(s_out_valid), 128'd0);

        // Single-register variant: combinational in_ready
        in_valid  = 1'b1;
        in_data   = 96'h21;
        in_ctrl   = 16'h0001;
        out_ready = 1'b0;
        #1;
        check("reg_empty_ready", 128'(r_in_ready), 128'd1);
        tick();
        check("reg_valid", 128'(r_out_valid), 128'd1);
        check("reg_data", 128'(r_out_data), 128'h21);
        in_data = 96'h22;
        in_ctrl = 16'h0002;
        #1;
        check("reg_stall_ready", 128'(r_in_ready), 128'd0);
        out_ready = 1'b1;
        #1;
        check("reg_comb_ready", 128'(r_in_ready), 128'd1);
        tick();
        check("reg_pass_data", 128'(r_out_data), 128'h22);
        check("reg_pass_ctrl", 128'(r_out_ctrl), 128'h0002);
        in_valid = 1'b0;
        tick();
        check("reg_drain", 128'(r_out_valid), 128'd0);
        check("reg_nop_ctrl", 128'(r_out_ctrl), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 96, width of the data payload (operands, immediate).
REQ-002 SHALL have parameter CTRL_W, default 16, width of the control payload (ALUOp, RegWrite, MemRead, ...).
REQ-003 SHALL have parameter SKID_EN, default 1; 1 selects a two-entry skid buffer, 0 selects a single register.
REQ-004 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-005 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, upstream beat present.
REQ-008 SHALL have port in_ready, output, 1, stage accepts a beat this cycle.
REQ-009 SHALL have port in_ctrl, input, CTRL_W, upstream control payload.
REQ-010 SHALL have port in_data, input, DATA_W, upstream data payload.
REQ-011 SHALL have port out_valid, output, 1, downstream beat present.
REQ-012 SHALL have port out_ready, input, 1, downstream consumes this cycle (deasserted = downstream stall).
REQ-013 SHALL have port out_ctrl, output, CTRL_W, control of the head entry.
REQ-014 SHALL have port out_data, output, DATA_W, data of the head entry.
REQ-015 SHALL have port flush, input, 1, kill all held entries and any beat accepted this cycle.
REQ-016 SHALL have port cnt_clr, input, 1, synchronous clear of both counters.
REQ-017 SHALL have port stall_cnt, output, CNT_W, cycles with out_valid=1 and out_ready=0.
REQ-018 SHALL have port bubble_cnt, output, CNT_W, cycles with out_valid=0 and out_ready=1.

Function
REQ-019 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-020 SHALL use the states EMPTY, HALF (head valid) and FULL (head and skid valid) when SKID_EN=1.
REQ-021 SHALL make these transitions, flush=0: EMPTY, in_fire -> HALF; HALF, in_fire only -> FULL (beat to skid); HALF, out_fire only -> EMPTY; HALF, both -> HALF (head <- input); FULL, out_fire -> HALF (head <- skid).
REQ-022 SHALL derive in_ready from registered state only when SKID_EN=1: 1 in EMPTY and HALF, 0 in FULL; no combinational path from out_ready.
REQ-023 SHALL implement SKID_EN=0 as a single register with in_ready = !out_valid | out_ready and no FULL state.
REQ-024 SHALL give a one-cycle latency from in_fire to out_valid when the stage is empty.
REQ-025 SHALL preserve beat order, with no beat lost or duplicated.
REQ-026 SHALL drive out_ctrl to all-zero whenever out_valid=0, so that bubbles are NOPs.
REQ-027 SHALL leave out_data holding its last value when out_valid=0; data is never zeroed except by reset.
REQ-028 SHALL, on flush=1, set next state to EMPTY and zero the control registers of all entries.
REQ-029 SHALL, on flush=1, discard any in_fire in the same cycle (control not captured) and leave data registers unchanged.
REQ-030 SHALL give flush priority over every handshake in the same cycle; the flush cycle's out_fire still counts as consumed downstream.
REQ-031 SHALL increment each counter by 1 per qualifying cycle, based on the current-cycle outputs, and saturate at 2^CNT_W-1 without wrapping.
REQ-032 SHALL give cnt_clr priority over increment; the counter reads 0 in the cycle after cnt_clr.

Reset
REQ-033 SHALL, while RST_N=0, asynchronously force state EMPTY, out_valid 0, out_ctrl 0, out_data 0, skid registers 0, stall_cnt 0, bubble_cnt 0.
REQ-034 SHALL present in_ready 1 in the first cycle after RST_N rises.
REQ-035 SHALL drop all held beats when reset is asserted mid-operation, with no partial update on release.

Structure
REQ-036 SHALL place the state enum (EMPTY/HALF/FULL) and the default parameter values in shared package pipe_pkg.
REQ-037 SHALL instantiate the sub-module pipe_sat_cnt (saturating counter with clear, parameter CNT_W) twice, for stall_cnt and bubble_cnt.

Verification
REQ-038 SHALL verify streaming: SKID_EN=1, in_valid=1 with data 1,2,3,4 and out_ready=1 -> out_data 1,2,3,4 on consecutive cycles starting one cycle later, in_ready stays 1.
REQ-039 SHALL verify the skid fill: stream 0xA,0xB, drop out_ready for 3 cycles -> state FULL, in_ready=0, stall_cnt=3; raise out_ready -> 0xA then 0xB, nothing lost.
REQ-040 SHALL verify flush in FULL with in_valid=1: next cycle out_valid=0, out_ctrl=0, out_data unchanged, in_ready=1, beat not delivered.
REQ-041 SHALL verify saturation with CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15; cnt_clr for one cycle -> 0 on the next cycle.
REQ-042 SHALL verify SKID_EN=0: out_ready=0 with in_valid=1 -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 combinationally.
REQ-043 SHALL verify reset in HALF: pulse RST_N low -> immediately out_valid=0 and all counters 0; after release in_ready=1.
